// File: rtl/sum_disp_pkg.sv
// Shared definitions for the sum display driver.
//   - scan_state_t : which of the four digit positions is being lit
//   - SEG_*        : active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_TABLE    : the 16 hex patterns, indexable by the hex digit
//   - SEG_BLANK    : all segments dark
//   - next_digit() : scan order DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0
package sum_disp_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Element 0 sits in the least significant bits, so SEG_TABLE[h] is the pattern for h.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  function automatic scan_state_t next_digit(input scan_state_t s);
    scan_state_t n;
    case (s)
      DIG0:    n = DIG1;
      DIG1:    n = DIG2;
      DIG2:    n = DIG3;
      DIG3:    n = DIG0;
      default: n = DIG0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sum_display_driver_if.sv
// Capture bus carrying the adder result into the display driver.
//   load : capture strobe, sum is sampled on a clk edge where load=1
//   sum  : 5-bit unsigned adder result (0..31)
// Modports: master drives the bus, slave (the display driver) samples it.
interface sum_display_driver_if;
  logic       load;
  logic [4:0] sum;

  modport master (output load, output sum);
  modport slave  (input load, input sum);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   hex : 4-bit digit 0..F
//   seg : active-low segments {g,f,e,d,c,b,a}
module seg7_decoder
  import sum_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup of the active-low pattern
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/sum_display_driver.sv
// Four-digit multiplexed seven-segment driver for a 5-bit adder result.
// The held value is shown as: DIG0 = decimal ones, DIG1 = decimal tens,
// DIG2 = hex of value[3:0], DIG3 = value[4]. Each digit stays lit for
// REFRESH_DIV clk cycles.
//
// Parameters:
//   REFRESH_DIV : clk cycles per digit slot (>= 1)
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : capture bus (load, sum), slave side
//   an    : digit anodes, active-low, registered
//   seg   : segments {g,f,e,d,c,b,a}, active-low, registered
//   dp    : decimal point, active-low, always off
// Build option:
//   SUM_DISP_LZ_BLANK_EN : when defined, a zero tens digit is left dark
//                          (slot timing is unaffected).
module sum_display_driver
  import sum_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  sum_display_driver_if.slave        bus,
  output logic [3:0]                 an,
  output logic [6:0]                 seg,
  output logic                       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [4:0]    value;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  scan_state_t   state;
  scan_state_t   state_next;
  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;

  assign dp = 1'b1;

  // Held value: captured on load, otherwise unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 5'd0;
    end else if (bus.load) begin
      value <= bus.sum;
    end else begin
      value <= value;
    end
  end

  // Scan state and refresh counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIG0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Refresh counter wraps at terminal count and advances the digit on the same edge
  always_comb begin
    count_next = count + CW'(1);
    state_next = state;
    if (count == TERM) begin
      count_next = '0;
      state_next = next_digit(state);
    end else begin
      count_next = count + CW'(1);
      state_next = state;
    end
  end

  // Decimal split by range compare; value is at most 31 so tens is 0..3
  always_comb begin
    tens = 2'd0;
    ones = 4'd0;
    if (value >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(value - 5'd30);
    end else if (value >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(value - 5'd20);
    end else if (value >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(value - 5'd10);
    end else begin
      tens = 2'd0;
      ones = value[3:0];
    end
  end

  // Select the digit to show and its anode for the current scan state
  always_comb begin
    nibble  = 4'd0;
    an_next = 4'b1111;
    case (state)
      DIG0: begin
        nibble  = ones;
        an_next = 4'b1110;
      end
      DIG1: begin
        nibble  = {2'b00, tens};
        an_next = 4'b1101;
      end
      DIG2: begin
        nibble  = value[3:0];
        an_next = 4'b1011;
      end
      DIG3: begin
        nibble  = {3'b000, value[4]};
        an_next = 4'b0111;
      end
      default: begin
        nibble  = 4'd0;
        an_next = 4'b1111;
      end
    endcase
  end

  seg7_decoder u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Segment pattern for the next cycle, with optional leading-zero blanking
  always_comb begin
    seg_next = dec_seg;
`ifdef SUM_DISP_LZ_BLANK_EN
    if ((state == DIG1) && (tens == 2'd0)) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = dec_seg;
    end
`endif
  end

  // Output registers; the blanked tens slot also darkens its anode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
`ifdef SUM_DISP_LZ_BLANK_EN
      an  <= (seg_next == SEG_BLANK) ? 4'b1111 : an_next;
`else
      an  <= an_next;
`endif
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Self-checking bench for sum_display_driver: two instances (REFRESH_DIV=4
// and REFRESH_DIV=1) share one capture bus and are compared every negedge
// against a behavioural model, plus literal checks of key scenarios.
module tb_sum_display_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;

  sum_display_driver_if bus ();

  logic [3:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic       dp4, dp1;

  sum_display_driver #(.REFRESH_DIV(4)) dut4 (
    .clk (clk), .reset (reset), .bus (bus), .an (an4), .seg (seg4), .dp (dp4)
  );

  sum_display_driver #(.REFRESH_DIV(1)) dut1 (
    .clk (clk), .reset (reset), .bus (bus), .an (an1), .seg (seg1), .dp (dp1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  // Expected {an,seg} for a value shown at digit position d
  function automatic logic [10:0] model_out(input int v, input int d);
    int h;
    logic [3:0] a;
    case (d)
      0:       h = v % 10;
      1:       h = v / 10;
      2:       h = v % 16;
      default: h = v / 16;
    endcase
    a = 4'b1111;
    a[d] = 1'b0;
`ifdef SUM_DISP_LZ_BLANK_EN
    if (d == 1 && v < 10) return {4'b1111, 7'b1111111};
`endif
    return {a, SEG_REF[h]};
  endfunction

  // Reference model: output at edge k shows the value held before edge k,
  // at digit position floor((k-1)/DIV) mod 4 counted from reset release.
  int edges = 0;
  int value_m = 0;
  logic [10:0] exp4 = {4'b1111, 7'b1111111};
  logic [10:0] exp1 = {4'b1111, 7'b1111111};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp4    <= {4'b1111, 7'b1111111};
      exp1    <= {4'b1111, 7'b1111111};
      edges   <= 0;
      value_m <= 0;
    end else begin
      exp4  <= model_out(value_m, (edges / 4) % 4);
      exp1  <= model_out(value_m, edges % 4);
      edges <= edges + 1;
      if (bus.load) value_m <= int'(bus.sum);
    end
  end

  always @(negedge clk) begin
    check("scan_div4", {an4, seg4}, exp4);
    check("scan_div1", {an1, seg1}, exp1);
    check("dp_off", {9'd0, dp4, dp1}, 11'd3);
  end

  task automatic wait_for(input bit sel1, input logic [3:0] target, input string tag);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 64) begin
      @(negedge clk);
      n++;
      if ((sel1 ? an1 : an4) == target) hit = 1'b1;
    end
    if (!hit) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout waiting for an=%b", tag, target);
    end
  endtask

  task automatic drive(input logic ld, input logic [4:0] s);
    @(negedge clk);
    #1;
    bus.load = ld;
    bus.sum  = s;
  endtask

  logic [3:0] an_lit  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_27  [4] = '{7'b1111000, 7'b0100100, 7'b0000011, 7'b1111001};
  logic [3:0] rot_lit [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    bus.load = 1'b0;
    bus.sum  = 5'd0;
    #1 reset = 1'b1;
    #1;
    check("reset_state_div4", {an4, seg4}, {4'b1111, 7'b1111111});
    check("reset_state_div1", {an1, seg1}, {4'b1111, 7'b1111111});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("first_after_reset_div4", {an4, seg4}, {4'b1110, 7'b1000000});
    check("first_after_reset_div1", {an1, seg1}, {4'b1110, 7'b1000000});

    // sum toggles with load low: display stays on value 0
    for (int i = 0; i < 40; i++) drive(1'b0, 5'(i % 32));
    @(negedge clk);
    check("hold_zero_div4_seg", {4'd0, seg4}, {4'd0, 7'b1000000});

    // anode rotation at REFRESH_DIV=1 including wrap
    wait_for(1'b1, 4'b1110, "rot_sync");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rot_div1", {7'd0, an1}, {7'd0, rot_lit[k]});
    end

    // load 27 and walk one full scan at REFRESH_DIV=4
    drive(1'b1, 5'd27);
    drive(1'b0, 5'd0);
    wait_for(1'b0, 4'b0111, "scan27_dig3");
    wait_for(1'b0, 4'b1110, "scan27_dig0");
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check("scan27_div4", {an4, seg4}, {an_lit[k / 4], seg_27[k / 4]});
    end

    // load 9 in the middle of the tens slot
    wait_for(1'b0, 4'b1101, "mid_dig1");
    #1;
    bus.load = 1'b1;
    bus.sum  = 5'd9;
    @(negedge clk);
    #1 bus.load = 1'b0;
    check("mid_dig1_old", {an4, seg4}, {4'b1101, 7'b0100100});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
`ifdef SUM_DISP_LZ_BLANK_EN
      check("mid_dig1_new", {an4, seg4}, {4'b1111, 7'b1111111});
`else
      check("mid_dig1_new", {an4, seg4}, {4'b1101, 7'b1000000});
`endif
    end
    @(negedge clk);
    check("mid_dig1_boundary", {an4, seg4}, {4'b1011, 7'b0010000});

    // reset asserted in the middle of the DIG2 slot
    #2 reset = 1'b1;
    #1;
    check("reset_mid_dig2_div4", {an4, seg4}, {4'b1111, 7'b1111111});
    check("reset_mid_dig2_div1", {an1, seg1}, {4'b1111, 7'b1111111});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("restart_div4", {an4, seg4}, {4'b1110, 7'b1000000});

    // randomized loads against the model
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 5'($urandom_range(0, 31)));
    end
    drive(1'b0, 5'd0);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_display_driver.md
SUM_DISPLAY_DRIVER -- requirements
Module: sum_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit; legal range >= 1.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  capture strobe; sum sampled on a clk edge where load=1.
REQ-005 SHALL have port sum  input  5  registered 5-bit adder result, unsigned 0..31.
REQ-006 SHALL have port an  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-007 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, constant 1 (off).

Function
REQ-009 SHALL hold a 5-bit value register; load=1 at edge N -> register = sum at N; load=0 -> hold; sum changes with load=0 have no effect.
REQ-010 SHALL derive tens = value/10 (0..3) and ones = value%10 (0..9) from the held value, combinationally, no divider.
REQ-011 SHALL scan four states DIG0->DIG1->DIG2->DIG3->DIG0; DIG0 = ones, DIG1 = tens, DIG2 = hex of value[3:0], DIG3 = value[4] (0 or 1).
REQ-012 SHALL keep a refresh counter 0..REFRESH_DIV-1; at terminal count: counter -> 0 and state advances same edge; REFRESH_DIV=1 advances every cycle.
REQ-013 SHALL register an and seg: the values at edge N+1 reflect state and held value after edge N (one-cycle latency from load to seg).
REQ-014 SHALL drive an = 1110/1101/1011/0111 for DIG0/DIG1/DIG2/DIG3.
REQ-015 SHALL encode hex 0..F to standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 7=1111000, B=0000011).
REQ-016 SHALL, on load during any digit slot, leave state and counter undisturbed; only seg content changes.
REQ-017 SHALL never light two anodes in the same cycle, including across state transitions.

Reset
REQ-018 SHALL, on reset=1, immediately (asynchronously) force an=1111, seg=1111111, value=0, counter=0, state=DIG0.
REQ-019 SHALL, on first edge after reset release, drive an=1110, seg=1000000 (digit 0 of value 0).
REQ-020 SHALL abort any scan in progress when reset asserts mid-operation; no partial-slot carry-over.

Configuration
REQ-021 SHALL recognise macro SUM_DISP_LZ_BLANK_EN: defined -> during DIG1 with tens=0, an=1111 and seg=1111111 (digit dark, slot timing unchanged); undefined -> tens=0 shown as "0".

Structure
REQ-022 SHALL place scan-state enum, 16-entry segment pattern constants and blank pattern in shared package sum_disp_pkg.
REQ-023 SHALL instantiate one combinational sub-module seg7_decoder (4-bit hex in, 7-bit active-low seg out).

Verification
REQ-024 SHALL cover: reset asserted mid-DIG2 -> an=1111, seg=1111111 same cycle, before next clk edge.
REQ-025 SHALL cover: REFRESH_DIV=4, load sum=27 -> DIG0 seg=1111000 (7) 4 cycles, DIG1 seg=0100100 (2), DIG2 seg=0000011 (B), DIG3 seg=1111001 (1).
REQ-026 SHALL cover: REFRESH_DIV=1 -> an cycles 1110,1101,1011,0111,1110 on consecutive edges (wrap).
REQ-027 SHALL cover: load sum=9 in mid-DIG1 slot -> seg changes next cycle, slot boundary cycle unchanged; with SUM_DISP_LZ_BLANK_EN, DIG1 an=1111.
REQ-028 SHALL cover: load=0 while sum toggles 0..31 -> an/seg sequence identical to held value 0 sequence.
